adder_pipe: RTL
===============

// Module: adder_pipe
// PURPOSE
//   Parametrised, pipelined two-operand adder/subtractor. Successor to the
//   combinational 4-bit ripple adder.
//   - WIDTH is split into SEG-bit ripple segments, with one register stage
//     per segment. The carry moves forward one stage per cycle, so the clock
//     rate is independent of WIDTH.
//   - Adds carry-in, carry-out, signed overflow, a subtract mode and
//     valid/ready flow control, so it sits directly in streaming datapaths.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; WIDTH % SEG must be 0, otherwise elaboration fails
//   SEG     4  bits per pipeline segment; STAGES = WIDTH/SEG
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      block accepts a beat this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add only; ignored when sub=1)
//   sub        in   1      0: s=a+b+cin   1: s=a-b (a + ~b + 1)
//   out_valid  out  1      result beat valid
//   out_ready  in   1      downstream accepts result
//   s          out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//   ovf        out  1      two's-complement signed overflow
// BEHAVIOUR
//   - Reset (async assert, sync release): all stage valids, s, cout and ovf
//     clear to 0; out_valid=0. Reset mid-operation discards all in-flight
//     beats.
//   - Handshake: a beat transfers when valid&&ready on either side.
//     stall = out_valid && !out_ready. in_ready = !stall.
//   - Pipeline advance: while !stall, the whole pipe advances one stage per
//     cycle. While stall, every stage, including skew registers, holds.
//   - Latency: exactly STAGES cycles from input accept to out_valid when
//     unstalled. Throughput is 1 beat per cycle; bubbles propagate as
//     valid=0.
//   - Stage k (0..STAGES-1): adds segment k of a and b' (b'=sub?~b:b)
//     plus the carry from stage k-1 registered in the previous cycle.
//     Stage 0 uses carry (sub?1:cin).
//   - Skew registers: upper operand segments are delayed k cycles before
//     stage k. Lower result segments are delayed (STAGES-1-k) cycles, so
//     s is aligned at the output.
//   - cout is the carry out of stage STAGES-1.
//     ovf = (a[MSB]==b'[MSB]) && (s[MSB]!=a[MSB]), computed in the final
//     stage.
//   - Data registers of invalid stages may hold stale values, but s, cout
//     and ovf are only meaningful while out_valid=1.
//   - Simultaneous accept at the input and drain at the output in the same
//     cycle is allowed; there is no loss or duplication. Output order
//     equals input order.
//   - STAGES=1 degenerates to a single registered adder with latency 1.
// CONFIGURATION
//   ADDER_PIPE_SAT_EN defined: when ovf=1, s saturates to 2^(WIDTH-1)-1 on
//     positive overflow or -2^(WIDTH-1) on negative overflow. The sign is
//     taken from a[MSB]. cout and ovf are unchanged.
//   ADDER_PIPE_SAT_EN undefined: s always wraps modulo 2^WIDTH.
// STRUCTURE
//   adder_pkg: default WIDTH/SEG localparams and a function that computes
//     STAGES and checks divisibility.
//   adder_seg: one SEG-bit ripple slice (a, b, ci -> s, co), purely
//     combinational. It is instantiated STAGES times in a generate loop;
//     registers and skew live in adder_pipe.
// TESTING  (WIDTH=16, SEG=4, latency 4 unless noted)
//   1. Reset: assert rst_n=0 mid-cycle -> out_valid=0, s=0, cout=0, ovf=0
//      immediately (async).
//   2. Add: a=0x0001, b=0xFFFF, cin=0, sub=0 -> 4 cycles later s=0x0000,
//      cout=1, ovf=0.
//   3. Overflow: a=0x7FFF, b=0x0001 -> s=0x8000, ovf=1, cout=0
//      (SAT_EN: s=0x7FFF).
//   4. Subtract: a=0x0003, b=0x0005, sub=1 -> s=0xFFFE, cout=0, ovf=0.
//      a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, ovf=1 (SAT_EN: s=0x8000).
//   5. Stream 8 random beats back-to-back and hold out_ready=0 for 3 cycles
//      mid-stream -> in_ready=0 exactly while stalled; all 8 results
//      correct and in order.
//   6. Reset during the stream with 3 beats in flight -> after release,
//      out_valid stays 0 until a new beat has aged 4 cycles; no stale beat
//      emerges.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared defaults for the pipelined adder and the helper that derives the
// pipeline depth from the operand width and the segment width.
package adder_pkg;

  localparam int unsigned ADDER_WIDTH = 16;
  localparam int unsigned ADDER_SEG   = 4;

  // Returns 0 for an unusable width/segment pair so the top can refuse to elaborate.
  function automatic int unsigned adder_stages(input int unsigned width,
                                               input int unsigned seg);
    if (seg == 0 || width == 0 || (width % seg) != 0) return 0;
    return width / seg;
  endfunction

endpackage

// File: rtl/adder_seg.sv
// One SEG-bit ripple slice of the pipelined adder; purely combinational.
module adder_seg #(
  parameter int unsigned SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);

  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined adder/subtractor: one SEG-bit slice per register stage, carry
// advances one stage per cycle. Define ADDER_PIPE_SAT_EN to saturate s on overflow.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH,
  parameter int unsigned SEG   = ADDER_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = adder_stages(WIDTH, SEG);
  localparam int unsigned OPS    = (STAGES > 1) ? STAGES - 1 : 1;

  if (STAGES == 0) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be a non-zero multiple of SEG");
  end

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             fin_a_msb;
  logic             fin_b_msb;

  logic [SEG-1:0]   seg_a  [STAGES];
  logic [SEG-1:0]   seg_b  [STAGES];
  logic [SEG-1:0]   seg_s  [STAGES];
  logic             seg_ci [STAGES];
  logic             seg_co [STAGES];

  logic [STAGES-1:0] vld_d, vld_q;
  logic [STAGES-1:0] carry_d, carry_q;
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  opa_d [OPS];
  logic [WIDTH-1:0]  opa_q [OPS];
  logic [WIDTH-1:0]  opb_d [OPS];
  logic [WIDTH-1:0]  opb_q [OPS];
  logic              ovf_d, ovf_q;

`ifdef ADDER_PIPE_SAT_EN
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] val,
                                                input logic             of,
                                                input logic             neg);
    if (!of) return val;
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  // Stage k sees operand segment k after k cycles of skew; stage 0 uses the live inputs.
  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    if (k == 0) begin : g_first
      assign seg_a[k]  = a[SEG-1:0];
      assign seg_b[k]  = b_eff[SEG-1:0];
      assign seg_ci[k] = c0;
    end else begin : g_rest
      assign seg_a[k]  = opa_q[k-1][k*SEG +: SEG];
      assign seg_b[k]  = opb_q[k-1][k*SEG +: SEG];
      assign seg_ci[k] = carry_q[k-1];
    end

    adder_seg #(.SEG(SEG)) u_seg (
      .a  (seg_a[k]),
      .b  (seg_b[k]),
      .ci (seg_ci[k]),
      .s  (seg_s[k]),
      .co (seg_co[k])
    );
  end

  if (STAGES == 1) begin : g_msb_direct
    assign fin_a_msb = a[WIDTH-1];
    assign fin_b_msb = b_eff[WIDTH-1];
  end else begin : g_msb_skew
    assign fin_a_msb = opa_q[STAGES-2][WIDTH-1];
    assign fin_b_msb = opb_q[STAGES-2][WIDTH-1];
  end

  always_comb begin
    stall    = vld_q[STAGES-1] && !out_ready;
    in_ready = !stall;
    b_eff    = sub ? ~b : b;
    c0       = sub | cin;

    vld_d   = vld_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    ovf_d   = ovf_q;

    if (!stall) begin
      vld_d[0] = in_valid;
      for (int k = 1; k < STAGES; k++) vld_d[k] = vld_q[k-1];

      for (int k = 0; k < STAGES; k++) carry_d[k] = seg_co[k];

      // Each stage ORs its slice into the partial sum handed on from the stage below.
      sum_d[0] = WIDTH'(seg_s[0]);
      for (int k = 1; k < STAGES; k++)
        sum_d[k] = sum_q[k-1] | (WIDTH'(seg_s[k]) << (k * SEG));

      opa_d[0] = a;
      opb_d[0] = b_eff;
      for (int k = 1; k < OPS; k++) begin
        opa_d[k] = opa_q[k-1];
        opb_d[k] = opb_q[k-1];
      end

      ovf_d = (fin_a_msb == fin_b_msb) && (seg_s[STAGES-1][SEG-1] != fin_a_msb);
`ifdef ADDER_PIPE_SAT_EN
      sum_d[STAGES-1] = saturate(sum_d[STAGES-1], ovf_d, fin_a_msb);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) sum_q[k] <= '0;
      for (int k = 0; k < OPS; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign s         = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule
